// File: rtl/pushbutton_edge_capture_if.sv
// pushbutton_edge_capture_if: Avalon-MM register bus between a host (master) and the key block (slave).
// Signals: address[1:0], chipselect, read, write, writedata[31:0] from master; readdata[31:0] from slave.
interface pushbutton_edge_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, read, write, writedata, input readdata);
    modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/pushbutton_edge_capture.sv
// pushbutton_edge_capture: synchronise, debounce, edge-capture and count NUM_KEYS pushbuttons behind an Avalon-MM slave.
// Ports: clk, reset (sync, active high); bus (slave modport: address/chipselect/read/write/writedata/readdata);
//        i_pushbuttons (raw async pins); o_irq (registered level interrupt, |(EDGE & MASK)).
// Registers: 0 DATA RO, 1 EDGE W1C, 2 MASK RW, 3 COUNT RW (any write clears, saturating press count).
module pushbutton_edge_capture #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    pushbutton_edge_capture_if.slave      bus,
    input  logic [NUM_KEYS-1:0]           i_pushbuttons,
    output logic                          o_irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [NUM_KEYS-1:0] IDLE_PIN = ACTIVE_LOW ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};
    // Accept on the cycle the counter would reach DEBOUNCE_CYCLES, so the update lands exactly then.
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] r_sync1, r_sync2, r_deb, r_edge, r_mask;
    logic [NUM_KEYS-1:0] w_synced, w_deb_nxt, w_press, w_edge_clr;
    logic [CW-1:0]       r_cnt     [NUM_KEYS];
    logic [CW-1:0]       w_cnt_nxt [NUM_KEYS];
    logic [15:0]         r_count;
    logic [5:0]          w_pop;
    logic [16:0]         w_sum;
    logic [31:0]         r_rdata, w_rd_mux;
    logic                r_irq, w_wr;

    assign w_synced = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    // A mismatch cycle advances the count; any matching cycle (glitch back) restarts it.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_deb_nxt[i] = r_deb[i];
            w_cnt_nxt[i] = '0;
            if (w_synced[i] != r_deb[i]) begin
                if (r_cnt[i] == LAST) w_deb_nxt[i] = w_synced[i];
                else w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
            w_pop = w_pop + 6'(w_deb_nxt[i] & ~r_deb[i]);
        end
    end

    assign w_press    = w_deb_nxt & ~r_deb;
    assign w_wr       = bus.chipselect & bus.write;
    assign w_edge_clr = (w_wr && bus.address == 2'd1) ? bus.writedata[NUM_KEYS-1:0] : '0;
    // A clear write and same-cycle presses leave just that cycle's presses.
    assign w_sum      = ((w_wr && bus.address == 2'd3) ? 17'd0 : {1'b0, r_count}) + 17'(w_pop);
    assign w_rd_mux   = bus.address == 2'd0 ? 32'(r_deb)  :
                        bus.address == 2'd1 ? 32'(r_edge) :
                        bus.address == 2'd2 ? 32'(r_mask) : {16'd0, r_count};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= IDLE_PIN;
            r_sync2 <= IDLE_PIN;
            r_deb   <= '0;
            r_edge  <= '0;
            r_mask  <= '0;
            r_count <= '0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
            for (int i = 0; i < NUM_KEYS; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= i_pushbuttons;
            r_sync2 <= r_sync1;
            r_deb   <= w_deb_nxt;
            for (int i = 0; i < NUM_KEYS; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_edge  <= (r_edge & ~w_edge_clr) | w_press;
            if (w_wr && bus.address == 2'd2) r_mask <= bus.writedata[NUM_KEYS-1:0];
            r_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
            r_irq   <= |(r_edge & r_mask);
            r_rdata <= (bus.chipselect && bus.read) ? w_rd_mux : '0;
        end
    end

    assign bus.readdata = r_rdata;
    assign o_irq        = r_irq;
endmodule

// File: tb/tb_pushbutton_edge_capture.sv
// tb_pushbutton_edge_capture: directed self-checking bench for pushbutton_edge_capture.
module tb_pushbutton_edge_capture;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  pins;
    logic [31:0] s_pins;
    logic        irq, s_irq;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pushbutton_edge_capture_if bus_if ();
    pushbutton_edge_capture_if sat_if ();

    pushbutton_edge_capture #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(rst), .bus(bus_if), .i_pushbuttons(pins), .o_irq(irq));

    pushbutton_edge_capture #(.NUM_KEYS(32), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(0)) sat (
        .clk(clk), .reset(rst), .bus(sat_if), .i_pushbuttons(s_pins), .o_irq(s_irq));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write      = 1'b1;
        bus_if.address    = a;
        bus_if.writedata  = d;
        tick();
        bus_if.chipselect = 1'b0;
        bus_if.write      = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.address    = a;
        tick();
        check(tag, bus_if.readdata, exp);
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
    endtask

    task automatic hold_read(input logic [1:0] a);
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        bus_if.address    = a;
    endtask

    task automatic drop_read();
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
    endtask

    initial begin
        bus_if.chipselect = 0; bus_if.read = 0; bus_if.write = 0;
        bus_if.address = 0; bus_if.writedata = 0;
        sat_if.chipselect = 0; sat_if.read = 0; sat_if.write = 0;
        sat_if.address = 0; sat_if.writedata = 0;
        pins = 4'hF;
        s_pins = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_rdata", bus_if.readdata, 0);
        check("reset_irq", 32'(irq), 0);
        rd("reset_data", 2'd0, 0);
        rd("reset_edge", 2'd1, 0);
        rd("reset_mask", 2'd2, 0);
        rd("reset_count", 2'd3, 0);
        tick();
        check("rdata_idle", bus_if.readdata, 0);

        // key0 press: DATA appears 6 cycles after the pin change
        hold_read(2'd0);
        pins = 4'b1110;
        repeat (6) tick();
        check("data_early", bus_if.readdata, 0);
        tick();
        check("data_latency", bus_if.readdata, 1);
        drop_read();
        rd("press_edge", 2'd1, 1);
        rd("press_count", 2'd3, 1);
        check("press_irq_masked", 32'(irq), 0);

        // release sets no edge
        pins = 4'hF;
        repeat (10) tick();
        rd("release_data", 2'd0, 0);
        rd("release_edge", 2'd1, 1);
        rd("release_count", 2'd3, 1);
        wr(2'd1, 32'hF);
        wr(2'd3, 32'h1234);
        rd("w1c_edge", 2'd1, 0);
        rd("clear_count", 2'd3, 0);

        // bounce: low 2 / high 2 never reaches 4 stable cycles
        for (int i = 0; i < 20; i++) begin
            pins[0] = (i % 4 < 2) ? 1'b0 : 1'b1;
            tick();
        end
        pins = 4'hF;
        repeat (10) tick();
        rd("bounce_data", 2'd0, 0);
        rd("bounce_edge", 2'd1, 0);
        rd("bounce_count", 2'd3, 0);

        // irq follows EDGE & MASK one cycle later
        wr(2'd2, 32'h1);
        pins = 4'b1110;
        repeat (6) tick();
        check("irq_early", 32'(irq), 0);
        tick();
        check("irq_set", 32'(irq), 1);
        wr(2'd1, 32'h1);
        check("irq_hold", 32'(irq), 1);
        tick();
        check("irq_clear", 32'(irq), 0);
        pins = 4'hF;
        repeat (10) tick();

        // W1C in the same cycle as the press: set wins
        pins = 4'b1110;
        repeat (5) tick();
        wr(2'd1, 32'h1);
        check("race_irq_early", 32'(irq), 0);
        tick();
        check("race_irq", 32'(irq), 1);
        rd("race_edge", 2'd1, 1);
        rd("race_count", 2'd3, 2);
        pins = 4'hF;
        repeat (10) tick();
        wr(2'd1, 32'hF);
        wr(2'd2, 32'h0);
        wr(2'd3, 32'h0);

        // all four keys together add 4 in one cycle
        hold_read(2'd3);
        pins = 4'b0000;
        repeat (6) tick();
        check("multi_count_early", bus_if.readdata, 0);
        tick();
        check("multi_count", bus_if.readdata, 4);
        drop_read();
        rd("multi_data", 2'd0, 4'hF);
        rd("multi_edge", 2'd1, 4'hF);
        check("multi_irq", 32'(irq), 0);

        // reset mid-debounce with key1 held
        pins = 4'hF;
        repeat (10) tick();
        wr(2'd2, 32'hF);
        tick();
        check("mask_irq", 32'(irq), 1);
        pins = 4'b1101;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_rdata", bus_if.readdata, 0);
        check("midrst_irq", 32'(irq), 0);
        hold_read(2'd0);
        repeat (6) tick();
        check("held_early", bus_if.readdata, 0);
        tick();
        check("held_data", bus_if.readdata, 2);
        drop_read();
        rd("midrst_mask", 2'd2, 0);
        rd("midrst_edge", 2'd1, 2);
        rd("midrst_count", 2'd3, 1);
        check("midrst_irq_after", 32'(irq), 0);

        // saturation: 32 keys toggled every cycle on a DEBOUNCE_CYCLES=1 instance
        sat_if.chipselect = 1'b1;
        sat_if.read       = 1'b1;
        sat_if.address    = 2'd3;
        for (int n = 0; n < 41; n++) begin
            s_pins = ~s_pins;
            tick();
        end
        check("sat_partial", sat_if.readdata, 608);
        for (int n = 0; n < 4959; n++) begin
            s_pins = ~s_pins;
            tick();
        end
        check("sat_full", sat_if.readdata, 32'hFFFF);
        for (int n = 0; n < 20; n++) begin
            s_pins = ~s_pins;
            tick();
        end
        check("sat_hold", sat_if.readdata, 32'hFFFF);
        sat_if.chipselect = 1'b0;
        sat_if.read       = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
